// File: rtl/hsv_to_rgb_pipe.sv
// Streaming 3-stage HSV->RGB converter (hue sectors of width 43) with valid/ready on both sides.
// Define HSV2RGB_SKID_EN for a 2-entry output skid buffer and a registered in_ready.
module hsv_to_rgb_pipe #(
  parameter int unsigned USER_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_h,
  input  logic [7:0]        in_s,
  input  logic [7:0]        in_v,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic [USER_W-1:0] out_user
);

  // Whole-pipe advance; every stage freezes together when low.
  logic adv;

  logic              s1_valid_q, s1_valid_d;
  logic [7:0]        s1_c_q, s1_c_d;
  logic [7:0]        s1_m_q, s1_m_d;
  logic [7:0]        s1_v_q, s1_v_d;
  logic [7:0]        s1_f_q, s1_f_d;
  logic [2:0]        s1_sec_q, s1_sec_d;
  logic [USER_W-1:0] s1_user_q, s1_user_d;

  logic              s2_valid_q, s2_valid_d;
  logic [7:0]        s2_x_q, s2_x_d;
  logic [7:0]        s2_m_q, s2_m_d;
  logic [7:0]        s2_v_q, s2_v_d;
  logic [2:0]        s2_sec_q, s2_sec_d;
  logic [USER_W-1:0] s2_user_q, s2_user_d;

  logic [15:0] sv_prod;
  logic [7:0]  c_new;
  logic [7:0]  f_new;
  logic [2:0]  sec_new;
  logic [15:0] cf_prod;
  logic [7:0]  x_new;
  logic [8:0]  mx_sum;
  logic [7:0]  mid;
  logic [7:0]  r3, g3, b3;

  always_comb begin
    sv_prod = 16'(in_s) * 16'(in_v);
    c_new   = 8'(sv_prod / 16'd255);
    if (in_h <= 8'd42) begin
      sec_new = 3'd0;
      f_new   = in_h;
    end else if (in_h <= 8'd84) begin
      sec_new = 3'd1;
      f_new   = 8'd85 - in_h;
    end else if (in_h <= 8'd127) begin
      sec_new = 3'd2;
      f_new   = in_h - 8'd85;
    end else if (in_h <= 8'd170) begin
      sec_new = 3'd3;
      f_new   = 8'd171 - in_h;
    end else if (in_h <= 8'd213) begin
      sec_new = 3'd4;
      f_new   = in_h - 8'd171;
    end else begin
      sec_new = 3'd5;
      f_new   = 8'(9'd256 - {1'b0, in_h});
    end

    s1_valid_d = s1_valid_q;
    s1_c_d     = s1_c_q;
    s1_m_d     = s1_m_q;
    s1_v_d     = s1_v_q;
    s1_f_d     = s1_f_q;
    s1_sec_d   = s1_sec_q;
    s1_user_d  = s1_user_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_c_d     = c_new;
      s1_m_d     = in_v - c_new;
      s1_v_d     = in_v;
      s1_f_d     = f_new;
      s1_sec_d   = sec_new;
      s1_user_d  = in_user;
    end
  end

  always_comb begin
    cf_prod = 16'(s1_c_q) * 16'(s1_f_q);
    x_new   = 8'(cf_prod / 16'd43);

    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_m_d     = s2_m_q;
    s2_v_d     = s2_v_q;
    s2_sec_d   = s2_sec_q;
    s2_user_d  = s2_user_q;
    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_x_d     = x_new;
      s2_m_d     = s1_m_q;
      s2_v_d     = s1_v_q;
      s2_sec_d   = s1_sec_q;
      s2_user_d  = s1_user_q;
    end
  end

  // Stage 3 channel mapping; m+X cannot exceed V but is clamped anyway.
  always_comb begin
    mx_sum = 9'(s2_m_q) + 9'(s2_x_q);
    mid    = mx_sum[8] ? 8'hff : mx_sum[7:0];
    case (s2_sec_q)
      3'd0:    {r3, g3, b3} = {s2_v_q, mid, s2_m_q};
      3'd1:    {r3, g3, b3} = {mid, s2_v_q, s2_m_q};
      3'd2:    {r3, g3, b3} = {s2_m_q, s2_v_q, mid};
      3'd3:    {r3, g3, b3} = {s2_m_q, mid, s2_v_q};
      3'd4:    {r3, g3, b3} = {mid, s2_m_q, s2_v_q};
      default: {r3, g3, b3} = {s2_v_q, s2_m_q, mid};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_c_q     <= '0;
      s1_m_q     <= '0;
      s1_v_q     <= '0;
      s1_f_q     <= '0;
      s1_sec_q   <= '0;
      s1_user_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_x_q     <= '0;
      s2_m_q     <= '0;
      s2_v_q     <= '0;
      s2_sec_q   <= '0;
      s2_user_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_c_q     <= s1_c_d;
      s1_m_q     <= s1_m_d;
      s1_v_q     <= s1_v_d;
      s1_f_q     <= s1_f_d;
      s1_sec_q   <= s1_sec_d;
      s1_user_q  <= s1_user_d;
      s2_valid_q <= s2_valid_d;
      s2_x_q     <= s2_x_d;
      s2_m_q     <= s2_m_d;
      s2_v_q     <= s2_v_d;
      s2_sec_q   <= s2_sec_d;
      s2_user_q  <= s2_user_d;
    end
  end

`ifdef HSV2RGB_SKID_EN
  localparam int unsigned EntW = USER_W + 24;

  // Stage 3 writes straight into the skid, so latency stays at 3.
  logic [EntW-1:0] skid_q [2];
  logic [EntW-1:0] skid_d [2];
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic            wr_q, wr_d;
  logic            rdy_q, rdy_d;
  logic            push, pop;

  assign adv      = rdy_q;
  assign in_ready = rdy_q;

  always_comb begin
    push   = s2_valid_q & adv;
    pop    = (cnt_q != 2'd0) & out_ready;
    skid_d = skid_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push) begin
      skid_d[wr_q] = {s2_user_q, r3, g3, b3};
      wr_d         = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_q[0] <= '0;
      skid_q[1] <= '0;
      cnt_q     <= 2'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdy_q     <= 1'b1;
    end else begin
      skid_q <= skid_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      rdy_q  <= rdy_d;
    end
  end

  assign out_valid                          = (cnt_q != 2'd0);
  assign {out_user, out_r, out_g, out_b}    = skid_q[rd_q];
`else
  logic              out_valid_q, out_valid_d;
  logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic [USER_W-1:0] user_q, user_d;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  always_comb begin
    out_valid_d = out_valid_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    user_d      = user_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      r_d         = r3;
      g_d         = g3;
      b_d         = b3;
      user_d      = s2_user_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      user_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      user_q      <= user_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = r_q;
  assign out_g     = g_q;
  assign out_b     = b_q;
  assign out_user  = user_q;
`endif

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// Scoreboard bench for hsv_to_rgb_pipe: accepted pixels queue a model result, a monitor pops
// and compares each output transfer; also checks latency, stall stability and mid-stream reset.
module tb_hsv_to_rgb_pipe;
  localparam int unsigned UW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_h = '0, in_s = '0, in_v = '0;
  logic [UW-1:0] in_user = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_r, out_g, out_b;
  logic [UW-1:0] out_user;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int stall_base = 0;
  int rmode = 0;
  int n_out = 0;
  logic [UW+23:0] exp_q [$];

  hsv_to_rgb_pipe #(.USER_W(UW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_h     (in_h),
    .in_s     (in_s),
    .in_v     (in_v),
    .in_user  (in_user),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_g    (out_g),
    .out_b    (out_b),
    .out_user (out_user)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: sector table plus a per-sector choice of which channel is max / min.
  function automatic logic [23:0] model_rgb(input int h, input int s, input int v);
    int bnd [7];
    int hi_ch [6];
    int lo_ch [6];
    int ch [3];
    int c, m, sec, f, x, mid;
    bnd   = '{0, 43, 85, 128, 171, 214, 256};
    hi_ch = '{0, 1, 1, 2, 2, 0};
    lo_ch = '{2, 2, 0, 0, 1, 1};
    c     = (s * v) / 255;
    m     = v - c;
    sec   = 0;
    for (int k = 0; k < 6; k++) if (h >= bnd[k] && h < bnd[k+1]) sec = k;
    f   = (sec % 2 == 0) ? h - bnd[sec] : bnd[sec+1] - h;
    x   = (c * f) / 43;
    mid = (m + x > 255) ? 255 : m + x;
    ch[hi_ch[sec]] = v;
    ch[lo_ch[sec]] = m;
    ch[3 - hi_ch[sec] - lo_ch[sec]] = mid;
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !((cyc - stall_base) >= 4 && (cyc - stall_base) <= 8);
      default: out_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (!reset && in_valid && in_ready)
      exp_q.push_back({in_user, model_rgb(int'(in_h), int'(in_s), int'(in_v))});
  end

  initial begin : monitor
    logic held_v;
    logic [UW+23:0] held_d, cur, exp;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        cur = {out_user, out_r, out_g, out_b};
        if (held_v) begin
          check("stall_valid", out_valid, 1);
          check("stall_hold", cur, held_d);
        end
        held_v = out_valid && !out_ready;
        held_d = cur;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pixel: got %0h, expected no pixel", cur);
          end else begin
            exp = exp_q.pop_front();
            check($sformatf("pixel%0d", n_out), cur, exp);
            n_out++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] h, input logic [7:0] s, input logic [7:0] v,
                      input logic [UW-1:0] u);
    int   w = 0;
    logic acc;
    in_valid = 1'b1;
    in_h     = h;
    in_s     = s;
    in_v     = v;
    in_user  = u;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      w++;
    end while (!acc && w < 500);
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
      finish_run();
    end
  endtask

  task automatic drain();
    int w = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Single pixel into an empty pipe with out_ready high; expects hand-computed RGB.
  task automatic directed(input string name, input logic [7:0] h, input logic [7:0] s,
                          input logic [7:0] v, input logic [7:0] er, input logic [7:0] eg,
                          input logic [7:0] eb);
    int lat = 1;
    check({name, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_h     = h;
    in_s     = s;
    in_v     = v;
    in_user  = 2'b10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_r"}, out_r, er);
    check({name, "_g"}, out_g, eg);
    check({name, "_b"}, out_b, eb);
    idle(2);
  endtask

  initial begin
    #1000000;
    checks++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    finish_run();
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_g", out_g, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_user", out_user, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);
    check("out_valid_after_reset", out_valid, 0);

    directed("red", 8'd0, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0);
    directed("green", 8'd85, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0);
    directed("blue", 8'd171, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255);
    directed("h43", 8'd43, 8'd255, 8'd255, 8'd249, 8'd255, 8'd0);
    directed("grey", 8'd200, 8'd0, 8'd100, 8'd100, 8'd100, 8'd100);
    directed("h255", 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd5);
    directed("h128", 8'd128, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255);
    directed("h170", 8'd170, 8'd255, 8'd255, 8'd0, 8'd5, 8'd255);
    directed("v0", 8'd100, 8'd200, 8'd0, 8'd0, 8'd0, 8'd0);
    drain();

    // 16-pixel burst with a scripted out_ready stall
    rmode      = 2;
    stall_base = cyc;
    for (int i = 0; i < 16; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           {(i == 0), (i == 15)});
    in_valid = 1'b0;
    rmode    = 0;
    drain();

    // Reset with three pixels in flight
    rmode = 3;
    idle(2);
    send(8'd10, 8'd255, 8'd255, 2'b10);
    send(8'd90, 8'd255, 8'd200, 2'b00);
    send(8'd180, 8'd128, 8'd255, 2'b01);
    in_valid = 1'b0;
    reset    = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("rst_flush_valid", out_valid, 0);
    reset = 1'b0;
    rmode = 0;
    idle(8);
    check("no_stale_valid", out_valid, 0);
    directed("post_reset", 8'd85, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0);

    // Full hue sweep at S=V=255 with random backpressure
    rmode = 1;
    for (int h = 0; h < 256; h++) send(8'(h), 8'd255, 8'd255, UW'($urandom_range(0, 3)));
    in_valid = 1'b0;
    rmode    = 0;
    drain();

    // Random pixels, random gaps, random backpressure
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           UW'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    rmode    = 0;
    drain();
    idle(4);
    finish_run();
  end

endmodule
